// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types for the program-counter generator.
//   addr            - 32-bit instruction address
//   pc_gen_state_e  - IDLE (post-reset), RUN (issuing), DRAIN (waiting out stale fetches)
//   INSTR_BYTES     - sequential PC increment
//   align_word()    - clears the byte-offset bits of a redirect target
package pc_gen_pkg;

    typedef logic [31:0] addr;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pc_gen_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    // Redirect targets may carry byte offsets; fetch always works on whole words.
    function automatic addr align_word(input addr a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_gen_checker.sv
// pc_gen_checker: protocol assertions for pc_gen, observing only its ports.
//   clk, rst                       - clock, async active-low reset
//   pc_valid/pc_ready/pc_data      - issue port
//   redirect_valid/redirect_ready  - redirect handshake
//   fetched_fire                   - fetch completion strobe
module pc_gen_checker #(
    parameter int unsigned MAX_INFLIGHT = 1
) (
    input logic        clk,
    input logic        rst,
    input logic        pc_valid,
    input logic        pc_ready,
    input logic [31:0] pc_data,
    input logic        redirect_valid,
    input logic        redirect_ready,
    input logic        fetched_fire
);

    int unsigned r_outstanding;
    logic        w_issue;
    logic        w_retire;

    assign w_issue  = pc_valid && pc_ready;
    assign w_retire = fetched_fire && (r_outstanding != 32'd0);

    // Independent count of PCs issued to fetch and not yet completed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= 32'd0;
        end else if (w_issue && !w_retire) begin
            r_outstanding <= r_outstanding + 32'd1;
        end else if (!w_issue && w_retire) begin
            r_outstanding <= r_outstanding - 32'd1;
        end else begin
            r_outstanding <= r_outstanding;
        end
    end

    a_no_spurious_fetch: assert property (@(posedge clk) disable iff (!rst)
        fetched_fire |-> (r_outstanding != 32'd0));

    a_inflight_bounded: assert property (@(posedge clk) disable iff (!rst)
        r_outstanding <= MAX_INFLIGHT);

    a_pc_stable: assert property (@(posedge clk) disable iff (!rst)
        (pc_valid && !pc_ready && !(redirect_valid && redirect_ready))
        |=> (pc_valid && $stable(pc_data)));

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator feeding instr_fetch.
// Issues sequential word addresses, throttled to MAX_INFLIGHT outstanding
// fetches. A redirect reloads the PC, pulses flush, and (if fetches are still
// outstanding) enters DRAIN where every returning beat is flagged discard.
// Ports:
//   clk, rst                                   - clock, async active-low reset
//   pc_valid, pc_ready, pc_data                - decoupled PC output to fetch
//   redirect_valid, redirect_ready, redirect_data - decoupled redirect input
//   fetched_fire                               - fetch completed a beat this cycle
//   flush                                      - one-cycle pulse after a redirect
//   discard                                    - current fetched beat is stale
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter addr         RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned MAX_INFLIGHT = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pc_valid,
    input  logic        pc_ready,
    output logic [31:0] pc_data,
    input  logic        redirect_valid,
    output logic        redirect_ready,
    input  logic [31:0] redirect_data,
    input  logic        fetched_fire,
    output logic        flush,
    output logic        discard
);

    localparam int unsigned   CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    pc_gen_state_e r_state;
    pc_gen_state_e w_state_nxt;
    addr           r_pc_q;
    addr           w_pc_nxt;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] w_inflight_nxt;
    logic          r_flush_q;

    logic          w_pc_valid;
    logic          w_redirect_ready;
    logic          w_pc_fire;
    logic          w_redir_fire;
    logic          w_retire;

    // Output decode; depends on registers only, so no path from pc_ready or fetched_fire.
    always_comb begin
        w_pc_valid       = 1'b0;
        w_redirect_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_pc_valid       = 1'b0;
                w_redirect_ready = 1'b0;
            end
            RUN: begin
                w_pc_valid       = (r_inflight < MAX_CNT);
                w_redirect_ready = 1'b1;
            end
            DRAIN: begin
                w_pc_valid       = 1'b0;
                w_redirect_ready = 1'b1;
            end
            default: begin
                w_pc_valid       = 1'b0;
                w_redirect_ready = 1'b0;
            end
        endcase
    end

    assign w_pc_fire    = w_pc_valid && pc_ready;
    assign w_redir_fire = redirect_valid && w_redirect_ready;
    // A completion with nothing outstanding is a protocol error; ignore it so the counter cannot underflow.
    assign w_retire     = fetched_fire && (r_inflight != '0);

    // In-flight counter: issue and completion in the same cycle cancel out.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_pc_fire && !w_retire) begin
            w_inflight_nxt = r_inflight + CNT_ONE;
        end else if (!w_pc_fire && w_retire) begin
            w_inflight_nxt = r_inflight - CNT_ONE;
        end else begin
            w_inflight_nxt = r_inflight;
        end
    end

    // Next state and next PC; a redirect beats a same-cycle issue, whose PC then counts as stale.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc_q;
        case (r_state)
            IDLE: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_redir_fire) begin
                    w_pc_nxt    = align_word(redirect_data);
                    w_state_nxt = (w_inflight_nxt != '0) ? DRAIN : RUN;
                end else if (w_pc_fire) begin
                    w_pc_nxt    = r_pc_q + addr'(INSTR_BYTES);
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_redir_fire) begin
                    w_pc_nxt    = align_word(redirect_data);
                    w_state_nxt = (w_inflight_nxt != '0) ? DRAIN : RUN;
                end else if (w_inflight_nxt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, PC, counter and flush registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pc_q     <= RESET_VECTOR;
            r_inflight <= '0;
            r_flush_q  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc_q     <= w_pc_nxt;
            r_inflight <= w_inflight_nxt;
            r_flush_q  <= w_redir_fire;
        end
    end

    assign pc_valid       = w_pc_valid;
    assign pc_data        = r_pc_q;
    assign redirect_ready = w_redirect_ready;
    assign flush          = r_flush_q;
    assign discard        = (r_state == DRAIN);

endmodule
